// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
//   fwd_sel_t  : ALU operand source select (register file, W, M)
//   hz_state_t : memory-wait sequencer state
//   PC_REG     : register number of the PC (never forwarded)
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN,
        MWAIT
    } hz_state_t;

    localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: selects the source of one Execute-stage ALU operand
//   ra_e        in  source register number in Execute
//   wa3_m/w     in  destination register numbers in Memory / Writeback
//   reg_write_m in  register write pending in Memory
//   reg_write_w in  register write pending in Writeback
//   sel         out operand source (Memory result wins over Writeback)
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [3:0] ra_e,
    input  logic [3:0] wa3_m,
    input  logic [3:0] wa3_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   sel
);

    // PC writes go through the branch path, so r15 is never forwarded
    always_comb
        sel = (reg_write_m && ra_e == wa3_m && wa3_m != PC_REG) ? FWD_M :
              (reg_write_w && ra_e == wa3_w && wa3_w != PC_REG) ? FWD_W : FWD_RF;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the F/D/E/M/W pipeline
//   clk, reset                 clock, asynchronous active-high reset
//   RA1D/RA2D, RA1E/RA2E       source registers in Decode / Execute
//   WA3E/WA3M/WA3W             destination registers in E/M/W
//   RegWriteM/W, MemtoRegE     write pending in M/W, load in E
//   PCWrPendingF, BranchTakenE PC write in flight, taken branch in E
//   MemReqM, mem_ready         data memory request in M and its completion
//   ForwardAE/BE               operand source select
//   StallF/D/E/M, FlushD/E/W   stage register hold / clear-to-bubble
//   mem_timeout                sticky memory-wait watchdog flag
//   HAZARD_PERF_EN adds stall_cycles, flush_events, mem_wait_cycles counters
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCWrPendingF,
    input  logic       BranchTakenE,
    input  logic       MemReqM,
    input  logic       mem_ready,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       mem_timeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNTW-1:0] stall_cycles,
    output logic [CNTW-1:0] flush_events,
    output logic [CNTW-1:0] mem_wait_cycles
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);

    fwd_sel_t  fwd_a, fwd_b;
    hz_state_t state, state_d;
    logic      mem_stall, ldr_stall;
    logic [CW-1:0] cnt, cnt_nx;

    fwd_unit u_fwd_a (.ra_e(RA1E), .wa3_m(WA3M), .wa3_w(WA3W),
                      .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_a));
    fwd_unit u_fwd_b (.ra_e(RA2E), .wa3_m(WA3M), .wa3_w(WA3W),
                      .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .sel(fwd_b));

    assign mem_stall = MemReqM & ~mem_ready;
    assign ldr_stall = MemtoRegE & (WA3E == RA1D | WA3E == RA2D);

    // Reset clears every stage; otherwise a memory stall freezes everything
    // and bubbles W, and a taken branch discards D so a load-use there is moot
    always_comb begin
        ForwardAE = reset ? FWD_RF : fwd_a;
        ForwardBE = reset ? FWD_RF : fwd_b;
        {StallF, StallD, StallE, StallM} = 4'b0000;
        {FlushD, FlushE, FlushW} = 3'b000;
        if (reset) begin
            {FlushD, FlushE, FlushW} = 3'b111;
        end else if (mem_stall) begin
            {StallF, StallD, StallE, StallM} = 4'b1111;
            FlushW = 1'b1;
        end else if (BranchTakenE) begin
            {FlushD, FlushE} = 2'b11;
        end else if (ldr_stall) begin
            {StallF, StallD} = 2'b11;
            FlushE = 1'b1;
        end else if (PCWrPendingF) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        if (state == RUN && mem_stall)
            state_d = MWAIT;
        else if (state == MWAIT && mem_ready)
            state_d = RUN;
    end

    assign cnt_nx = (cnt == CW'(TIMEOUT)) ? cnt : cnt + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_d;
            if (state == RUN && state_d == MWAIT)
                cnt <= '0;
            else if (state == MWAIT)
                cnt <= cnt_nx;
            if (state == MWAIT && cnt_nx == CW'(TIMEOUT))
                mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles    <= '0;
            flush_events    <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (StallF && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNTW'(1);
            if (FlushE && flush_events != '1)
                flush_events <= flush_events + CNTW'(1);
            if (mem_stall && mem_wait_cycles != '1)
                mem_wait_cycles <= mem_wait_cycles + CNTW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4)
module tb_pipe_hazard_ctrl;
    import hazard_pkg::*;

    logic clk, reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, BranchTakenE, MemReqM, mem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cycles, flush_events, mem_wait_cycles;
`endif
    int errors = 0;
    int checks = 0;
    logic [6:0] ctl;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNTW(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCWrPendingF(PCWrPendingF), .BranchTakenE(BranchTakenE),
        .MemReqM(MemReqM), .mem_ready(mem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events),
        .mem_wait_cycles(mem_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, PCWrPendingF, BranchTakenE, MemReqM, mem_ready} = '0;
    endtask

    task automatic reset_pulse;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1'b1;
        #2;
        checks++; if (ctl !== 7'b0000111) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0000111); end
        checks++; if ({ForwardAE, ForwardBE} !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", {ForwardAE, ForwardBE}); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
`ifdef HAZARD_PERF_EN
        checks++; if ({stall_cycles, flush_events, mem_wait_cycles} !== 48'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", stall_cycles, flush_events, mem_wait_cycles); end
`endif
        tick();
        reset = 1'b0;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL idle_ctl got=%b exp=%b", ctl, 7'b0); end
    endtask

    task automatic test_forward;
        clear_inputs();
        RegWriteM = 1; WA3M = 3; RA1E = 3; RegWriteW = 1; WA3W = 3;
        #1;
        checks++; if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m_prio got=%b exp=10", ForwardAE); end
        WA3M = 4;
        #1;
        checks++; if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w got=%b exp=01", ForwardAE); end
        WA3W = 15; RA1E = 15;
        #1;
        checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_pc_w got=%b exp=00", ForwardAE); end
        WA3M = 15;
        #1;
        checks++; if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_pc_m got=%b exp=00", ForwardAE); end
        WA3W = 7; RA2E = 7;
        #1;
        checks++; if (ForwardBE !== 2'b01) begin errors++; $display("FAIL fwdb_w got=%b exp=01", ForwardBE); end
        RegWriteW = 0;
        #1;
        checks++; if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdb_nowr got=%b exp=00", ForwardBE); end
        clear_inputs();
    endtask

    task automatic test_load_use;
        clear_inputs();
        MemtoRegE = 1; WA3E = 5; RA2D = 5; RA1D = 2;
        #1;
        checks++; if (ctl !== 7'b1100010) begin errors++; $display("FAIL ldr_ctl got=%b exp=%b", ctl, 7'b1100010); end
        tick();
        clear_inputs();
        RegWriteM = 1; WA3M = 5; RA2E = 5;
        #1;
        checks++; if (ForwardBE !== 2'b10) begin errors++; $display("FAIL ldr_fwd got=%b exp=10", ForwardBE); end
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL ldr_after got=%b exp=%b", ctl, 7'b0); end
        clear_inputs();
    endtask

    task automatic test_branch;
        clear_inputs();
        BranchTakenE = 1; MemtoRegE = 1; WA3E = 6; RA1D = 6;
        #1;
        checks++; if (ctl !== 7'b0000110) begin errors++; $display("FAIL br_ldr got=%b exp=%b", ctl, 7'b0000110); end
        clear_inputs();
        PCWrPendingF = 1;
        #1;
        checks++; if (ctl !== 7'b1000100) begin errors++; $display("FAIL pcwr got=%b exp=%b", ctl, 7'b1000100); end
        clear_inputs();
    endtask

    task automatic test_mem_wait;
        clear_inputs();
        reset_pulse();
        MemReqM = 1; BranchTakenE = 1;
        #1;
        checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL mem_c0_ctl got=%b exp=%b", ctl, 7'b1111001); end
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL mem_c0_state got=%0d exp=%0d", dut.state, RUN); end
        BranchTakenE = 0;
        for (int c = 1; c < 3; c++) begin
            tick();
            checks++; if (ctl !== 7'b1111001) begin errors++; $display("FAIL mem_c%0d_ctl got=%b exp=%b", c, ctl, 7'b1111001); end
            checks++; if (dut.state !== MWAIT) begin errors++; $display("FAIL mem_c%0d_state got=%0d exp=%0d", c, dut.state, MWAIT); end
        end
        tick();
        mem_ready = 1;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL mem_ready_ctl got=%b exp=%b", ctl, 7'b0); end
        tick();
        MemReqM = 0; mem_ready = 0;
        #1;
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL mem_exit_state got=%0d exp=%0d", dut.state, RUN); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL mem_no_timeout got=%b exp=0", mem_timeout); end
`ifdef HAZARD_PERF_EN
        checks++; if (mem_wait_cycles !== 16'd3) begin errors++; $display("FAIL perf_memwait got=%0d exp=3", mem_wait_cycles); end
        checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles); end
        checks++; if (flush_events !== 16'd0) begin errors++; $display("FAIL perf_flush got=%0d exp=0", flush_events); end
`endif
        MemReqM = 1; mem_ready = 1;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL mem_fast_ctl got=%b exp=%b", ctl, 7'b0); end
        tick();
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL mem_fast_state got=%0d exp=%0d", dut.state, RUN); end
        clear_inputs();
    endtask

    task automatic test_timeout;
        clear_inputs();
        reset_pulse();
        for (int c = 0; c < 6; c++) begin
            MemReqM = 1; mem_ready = 0;
            #1;
            checks++; if (mem_timeout !== (c >= 5)) begin errors++; $display("FAIL timeout_c%0d got=%b exp=%b", c, mem_timeout, c >= 5); end
            tick();
        end
        mem_ready = 1;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL timeout_release_ctl got=%b exp=%b", ctl, 7'b0); end
        tick();
        clear_inputs();
        #1;
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout); end
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL timeout_state got=%0d exp=%0d", dut.state, RUN); end
    endtask

    task automatic test_reset_mid_wait;
        clear_inputs();
        MemReqM = 1;
        tick();
        tick();
        checks++; if (dut.state !== MWAIT) begin errors++; $display("FAIL rmw_pre_state got=%0d exp=%0d", dut.state, MWAIT); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (dut.state !== RUN) begin errors++; $display("FAIL rmw_state got=%0d exp=%0d", dut.state, RUN); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rmw_timeout got=%b exp=0", mem_timeout); end
        checks++; if (ctl !== 7'b0000111) begin errors++; $display("FAIL rmw_ctl got=%b exp=%b", ctl, 7'b0000111); end
`ifdef HAZARD_PERF_EN
        checks++; if ({stall_cycles, flush_events, mem_wait_cycles} !== 48'd0) begin errors++; $display("FAIL rmw_perf got=%0d/%0d/%0d exp=0/0/0", stall_cycles, flush_events, mem_wait_cycles); end
`endif
        tick();
        reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
